// File: rtl/pwm_wave_ctrl_if.sv
// Configuration handshake bundle for pwm_wave_ctrl: a valid/ready offer of
// period, high time and start phase.
interface pwm_wave_ctrl_if #(
    parameter int unsigned WIDTH = 16
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [WIDTH-1:0] cfg_period;
    logic [WIDTH-1:0] cfg_high;
    logic [WIDTH-1:0] cfg_phase;

    modport master (
        output cfg_valid,
        output cfg_period,
        output cfg_high,
        output cfg_phase,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_period,
        input  cfg_high,
        input  cfg_phase,
        output cfg_ready
    );
endinterface

// File: rtl/pwm_wave_ctrl.sv
// Phase-delayed PWM generator with a single-entry pending configuration that
// only takes effect at period boundaries or when starting from idle.
module pwm_wave_ctrl #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned DEF_PERIOD = 40,
    parameter int unsigned DEF_HIGH   = 16,
    parameter int unsigned DEF_PHASE  = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    pwm_wave_ctrl_if.slave cfg,
    output logic           wave_out,
    output logic           period_start,
    output logic           busy
);

    typedef enum logic [1:0] {StIdle, StPhase, StRun} state_e;

    localparam logic [WIDTH-1:0] One       = WIDTH'(1);
    localparam logic [WIDTH-1:0] DefPeriod = WIDTH'(DEF_PERIOD);
    localparam logic [WIDTH-1:0] DefHigh   = WIDTH'(DEF_HIGH);
    localparam logic [WIDTH-1:0] DefPhase  = WIDTH'(DEF_PHASE);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d, pcnt_q, pcnt_d;
    logic [WIDTH-1:0] act_period_q, act_period_d, act_high_q, act_high_d;
    logic [WIDTH-1:0] act_phase_q, act_phase_d;
    logic [WIDTH-1:0] pend_period_q, pend_period_d, pend_high_q, pend_high_d;
    logic [WIDTH-1:0] pend_phase_q, pend_phase_d;
    logic             pend_valid_q, pend_valid_d;
    logic             wave_q, wave_d, pstart_q, pstart_d;

    logic             accept, apply;
    logic [WIDTH-1:0] start_phase, san_period, san_high;

    assign cfg.cfg_ready = !pend_valid_q;
    assign accept        = cfg.cfg_valid && !pend_valid_q;
    assign busy          = (state_q != StIdle);
    assign wave_out      = wave_q;
    assign period_start  = pstart_q;

    // Clamp at accept so the active set is always self-consistent.
    assign san_period = (cfg.cfg_period == '0) ? One : cfg.cfg_period;
    assign san_high   = (cfg.cfg_high > san_period) ? san_period : cfg.cfg_high;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pcnt_d        = pcnt_q;
        act_period_d  = act_period_q;
        act_high_d    = act_high_q;
        act_phase_d   = act_phase_q;
        pend_period_d = pend_period_q;
        pend_high_d   = pend_high_q;
        pend_phase_d  = pend_phase_q;
        pend_valid_d  = pend_valid_q;
        apply         = 1'b0;
        start_phase   = pend_valid_q ? pend_phase_q : act_phase_q;

        unique case (state_q)
            StIdle: begin
                if (en) begin
                    apply = pend_valid_q;
                    if (start_phase != '0) begin
                        state_d = StPhase;
                        pcnt_d  = '0;
                    end else begin
                        state_d = StRun;
                        cnt_d   = '0;
                    end
                end
            end
            StPhase: begin
                if (!en) begin
                    state_d = StIdle;
                    pcnt_d  = '0;
                end else if (pcnt_q == act_phase_q - One) begin
                    state_d = StRun;
                    cnt_d   = '0;
                    pcnt_d  = '0;
                end else begin
                    pcnt_d = pcnt_q + One;
                end
            end
            StRun: begin
                if (cnt_q == act_period_q - One) begin
                    cnt_d = '0;
                    // A stop leaves the pending set for the next start.
                    if (!en) state_d = StIdle;
                    else     apply   = pend_valid_q;
                end else begin
                    cnt_d = cnt_q + One;
                end
            end
            default: state_d = StIdle;
        endcase

        if (apply) begin
            act_period_d = pend_period_q;
            act_high_d   = pend_high_q;
            act_phase_d  = pend_phase_q;
            pend_valid_d = 1'b0;
        end
        // apply needs pend_valid_q=1, accept needs it 0: never both.
        if (accept) begin
            pend_period_d = san_period;
            pend_high_d   = san_high;
            pend_phase_d  = cfg.cfg_phase;
            pend_valid_d  = 1'b1;
        end

        wave_d   = (state_d == StRun) && (cnt_d < act_high_d);
        pstart_d = (state_d == StRun) && (cnt_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            pcnt_q        <= '0;
            act_period_q  <= DefPeriod;
            act_high_q    <= DefHigh;
            act_phase_q   <= DefPhase;
            pend_period_q <= '0;
            pend_high_q   <= '0;
            pend_phase_q  <= '0;
            pend_valid_q  <= 1'b0;
            wave_q        <= 1'b0;
            pstart_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pcnt_q        <= pcnt_d;
            act_period_q  <= act_period_d;
            act_high_q    <= act_high_d;
            act_phase_q   <= act_phase_d;
            pend_period_q <= pend_period_d;
            pend_high_q   <= pend_high_d;
            pend_phase_q  <= pend_phase_d;
            pend_valid_q  <= pend_valid_d;
            wave_q        <= wave_d;
            pstart_q      <= pstart_d;
        end
    end

endmodule

// File: tb/tb_pwm_wave_ctrl.sv
// Scoreboard bench for pwm_wave_ctrl: stimulus queues the expected per-cycle
// outputs, a negedge monitor pops and compares them against the DUT.
module tb_pwm_wave_ctrl;

    typedef struct {
        logic [3:0] v;   // {wave_out, period_start, busy, cfg_ready}
        string      tag;
        int         idx;
    } exp_t;

    logic clk;
    logic rst_n;
    logic en;
    logic wave_out, period_start, busy;

    exp_t  exp_q[$];
    string tag;
    int    n_cyc;
    int    n_checks;
    int    n_pass;

    pwm_wave_ctrl_if #(.WIDTH(16)) cfg_if ();

    pwm_wave_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .cfg          (cfg_if),
        .wave_out     (wave_out),
        .period_start (period_start),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one comparison per cycle that has a queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            logic [3:0] act;
            e   = exp_q.pop_front();
            act = {wave_out, period_start, busy, cfg_if.cfg_ready};
            n_checks++;
            if (act === e.v) n_pass++;
            else $display("FAIL %s cyc=%0d got {wave,pstart,busy,ready}=%b expected %b",
                          e.tag, e.idx, act, e.v);
        end
    end

    // Queue the expectation for the current cycle, then move past the next edge.
    task automatic cyc(input logic w, input logic ps, input logic b, input logic r);
        exp_t e;
        e.v   = {w, ps, b, r};
        e.tag = tag;
        e.idx = n_cyc;
        exp_q.push_back(e);
        n_cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_cycles(input int n, input int high, input int period,
                              input int start_cnt, input logic r);
        for (int k = 0; k < n; k++) begin
            int c;
            c = (start_cnt + k) % period;
            cyc(c < high, c == 0, 1'b1, r);
        end
    endtask

    task automatic set_cfg(input logic v, input int p, input int h, input int ph);
        cfg_if.cfg_valid  = v;
        cfg_if.cfg_period = 16'(p);
        cfg_if.cfg_high   = 16'(h);
        cfg_if.cfg_phase  = 16'(ph);
    endtask

    // Accept a config in IDLE, then start; the start edge applies it.
    task automatic load_and_start(input int p, input int h, input int ph);
        set_cfg(1'b1, p, h, ph);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        set_cfg(1'b0, 0, 0, 0);
        en = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "timeout");
    end

    initial begin
        n_cyc = 0; n_checks = 0; n_pass = 0;
        rst_n = 1'b0; en = 1'b0;
        set_cfg(1'b0, 0, 0, 0);
        @(posedge clk); #1;

        tag = "reset_state";
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b1;
        tag = "idle_after_reset";
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        tag = "default_40_16";
        en = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        run_cycles(85, 16, 40, 0, 1'b1);
        tag = "en_drop_graceful";
        en = 1'b0;
        run_cycles(35, 16, 40, 5, 1'b1);
        tag = "idle_after_stop";
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        tag = "phase_cfg_accept";
        set_cfg(1'b1, 10, 3, 5);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        set_cfg(1'b0, 0, 0, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        en = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        tag = "phase_delay";
        repeat (5) cyc(1'b0, 1'b0, 1'b1, 1'b1);
        tag = "run_10_3";
        run_cycles(20, 3, 10, 0, 1'b1);
        en = 1'b0;
        run_cycles(10, 3, 10, 0, 1'b1);
        cyc(1'b0, 1'b0, 0, 1'b1);
        tag = "phase_abort";
        en = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        en = 1'b0;
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        tag = "midperiod_cfg";
        load_and_start(40, 16, 0);
        run_cycles(20, 16, 40, 0, 1'b1);
        set_cfg(1'b1, 8, 4, 0);
        run_cycles(1, 16, 40, 20, 1'b1);
        tag = "held_second_cfg";
        set_cfg(1'b1, 6, 2, 0);
        run_cycles(19, 16, 40, 21, 1'b0);
        tag = "new_8_4";
        run_cycles(1, 4, 8, 0, 1'b1);
        set_cfg(1'b0, 0, 0, 0);
        run_cycles(7, 4, 8, 1, 1'b0);
        tag = "held_applied_6_2";
        run_cycles(12, 2, 6, 0, 1'b1);
        en = 1'b0;
        run_cycles(6, 2, 6, 0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        tag = "high_clamped";
        load_and_start(20, 50, 0);
        run_cycles(40, 20, 20, 0, 1'b1);
        set_cfg(1'b1, 0, 0, 0);
        run_cycles(1, 20, 20, 0, 1'b1);
        set_cfg(1'b0, 0, 0, 0);
        run_cycles(19, 20, 20, 1, 1'b0);
        tag = "period0_as_1";
        run_cycles(5, 0, 1, 0, 1'b1);
        tag = "wrap_accept_deferred";
        set_cfg(1'b1, 1, 1, 0);
        run_cycles(1, 0, 1, 0, 1'b1);
        set_cfg(1'b0, 0, 0, 0);
        run_cycles(1, 0, 1, 0, 1'b0);
        tag = "period1_high1";
        run_cycles(4, 1, 1, 0, 1'b1);
        en = 1'b0;
        run_cycles(1, 1, 1, 0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        tag = "reset_midperiod";
        load_and_start(30, 10, 0);
        run_cycles(5, 10, 30, 0, 1'b1);
        set_cfg(1'b1, 12, 6, 0);
        run_cycles(1, 10, 30, 5, 1'b1);
        set_cfg(1'b0, 0, 0, 0);
        run_cycles(4, 10, 30, 6, 1'b0);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (wave_out === 1'b0 && busy === 1'b0 && cfg_if.cfg_ready === 1'b1) n_pass++;
        else $display("FAIL reset_immediate got wave=%b busy=%b ready=%b",
                      wave_out, busy, cfg_if.cfg_ready);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b1;
        tag = "defaults_after_reset";
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        run_cycles(1, 16, 40, 0, 1'b1);
        en = 1'b0;
        run_cycles(39, 16, 40, 1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0)
            $display("FAIL %0d expectations left unchecked", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        if (n_checks >= 12 && n_pass == n_checks && exp_q.size() == 0) $display("PASS");
        else $display("FAIL %0d of %0d checks failed", n_checks - n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pwm_wave_ctrl.md
PWM_WAVE_CTRL -- requirements
Module: pwm_wave_ctrl

Interface
REQ-001 Parameter WIDTH, default 16: width of all period/high/phase counts, in clk cycles.
REQ-002 Parameter DEF_PERIOD, default 40: active period after reset.
REQ-003 Parameter DEF_HIGH, default 16: active high time after reset (duty 0.4).
REQ-004 Parameter DEF_PHASE, default 0: active start delay after reset.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 en  input  1  run request; level-sensitive.
REQ-008 cfg_valid  input  1  new configuration offered.
REQ-009 cfg_ready  output  1  configuration can be accepted.
REQ-010 cfg_period  input  WIDTH  period in cycles.
REQ-011 cfg_high  input  WIDTH  high time in cycles.
REQ-012 cfg_phase  input  WIDTH  delay from start to first period.
REQ-013 wave_out  output  1  registered square wave.
REQ-014 period_start  output  1  one-cycle pulse on the first cycle of each period.
REQ-015 busy  output  1  high whenever state is not IDLE.

Function
REQ-016 Registers: active set (period, high, phase), one pending set plus pending_valid, cycle counter cnt, phase counter pcnt, state in {IDLE, PHASE, RUN}.
REQ-017 Handshake: config accepted on an edge where cfg_valid && cfg_ready; cfg_ready = !pending_valid; accepted values written to pending set, pending_valid set.
REQ-018 Sanitising at accept: period 0 stored as 1; high > period stored as period.
REQ-019 Apply: pending copied to active and pending_valid cleared only when leaving IDLE or at a RUN period wrap; never mid-period.
REQ-020 IDLE: on edge with en=1, apply pending if valid; then go PHASE (pcnt=0) if phase != 0, else RUN (cnt=0).
REQ-021 PHASE: pcnt increments each cycle; on pcnt == phase-1 go RUN with cnt=0; en=0 in PHASE returns to IDLE next edge.
REQ-022 RUN: cnt increments; at cnt == period-1 wrap: cnt=0, apply pending if valid; if en=0 at wrap go IDLE instead (pending applied on next start).
REQ-023 wave_out flop = 1 exactly for cycles where state==RUN and cnt < active high; 0 in IDLE and PHASE.
REQ-024 period_start flop = 1 exactly for cycles where state==RUN and cnt==0.
REQ-025 Latency: en sampled at edge k with phase=0 -> wave_out and period_start high in cycle k+1.
REQ-026 high=0 -> wave_out stays 0 through the period; high=period -> wave_out stays 1; period=1, high=1 -> wave_out constant 1 and period_start every cycle.
REQ-027 Config accepted on the same edge as a wrap is not applied at that wrap; it applies at the next boundary.
REQ-028 en deassertion in RUN is graceful: the current period completes unmodified.

Reset
REQ-029 rst_n low forces immediately: state=IDLE, cnt=0, pcnt=0, wave_out=0, period_start=0, busy=0, pending_valid=0 (cfg_ready=1), active set = DEF_PERIOD/DEF_HIGH/DEF_PHASE.
REQ-030 Reset asserted mid-period aborts the wave within the same cycle; the pending config is discarded.

Verification
REQ-031 Reset release, en=1 with defaults -> wave_out repeats 16 high / 24 low; period_start every 40 cycles.
REQ-032 Config period=10, high=3, phase=5 accepted in IDLE, then en=1 -> 5 cycles low with busy=1, then repeating 3 high / 7 low.
REQ-033 Running 40/16; at cnt=20 send period=8, high=4 -> current period finishes as 16/24, next periods 4/4; cfg_ready low from accept until the wrap.
REQ-034 Second cfg_valid while pending_valid=1 -> cfg_ready=0, not accepted; held request accepted on the edge after the wrap.
REQ-035 Config high=50, period=20 -> wave constant 1; config period=0, high=0 -> period treated as 1, wave_out 0, period_start every cycle.
REQ-036 en dropped at cnt=5 of 40 -> wave finishes period, IDLE after cnt=39; rst_n pulsed low at cnt=10 -> wave_out=0, busy=0 in same cycle.
